// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scancode to PC-8001 key matrix path:
// sequencer states, controller register map, set-2 prefix bytes, keymap entry layout.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_SEND,
        ST_POLL,
        ST_FETCH,
        ST_CLR,
        ST_DECODE
    } state_t;

    localparam logic [1:0] ADDR_STAT = 2'd0;
    localparam logic [1:0] ADDR_RX   = 2'd1;
    localparam logic [1:0] ADDR_TX   = 2'd2;

    localparam logic [7:0] CODE_E0 = 8'hE0;
    localparam logic [7:0] CODE_E1 = 8'hE1;
    localparam logic [7:0] CODE_F0 = 8'hF0;
    localparam logic [7:0] CODE_AA = 8'hAA;
    localparam logic [7:0] CODE_FA = 8'hFA;

    // Bytes following E1 that belong to the Pause sequence
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef struct packed {
        logic [3:0] row;
        logic [2:0] col;
    } key_ent_t;

endpackage

// File: rtl/ps2_keymap.sv
// Combinational scancode-set-2 to PC-8001 matrix position ROM.
// Entries are written in octal so each literal reads as {row, col}.
module ps2_keymap
    import ps2_pkg::*;
(
    input  logic       ext,
    input  logic [7:0] code,
    output logic       hit,
    output logic [3:0] row,
    output logic [2:0] col
);

    key_ent_t ent;

    always_comb begin
        hit = 1'b1;
        ent = '0;
        case ({ext, code})
            9'h070: ent = 7'o000;  9'h069: ent = 7'o001;  9'h072: ent = 7'o002;  9'h07A: ent = 7'o003;
            9'h06B: ent = 7'o004;  9'h073: ent = 7'o005;  9'h074: ent = 7'o006;  9'h06C: ent = 7'o007;
            9'h075: ent = 7'o010;  9'h07D: ent = 7'o011;  9'h07C: ent = 7'o012;  9'h079: ent = 7'o013;
            9'h071: ent = 7'o016;  9'h05A: ent = 7'o017;  9'h15A: ent = 7'o017;
            9'h054: ent = 7'o020;  9'h01C: ent = 7'o021;  9'h032: ent = 7'o022;  9'h021: ent = 7'o023;
            9'h023: ent = 7'o024;  9'h024: ent = 7'o025;  9'h02B: ent = 7'o026;  9'h034: ent = 7'o027;
            9'h033: ent = 7'o030;  9'h043: ent = 7'o031;  9'h03B: ent = 7'o032;  9'h042: ent = 7'o033;
            9'h04B: ent = 7'o034;  9'h03A: ent = 7'o035;  9'h031: ent = 7'o036;  9'h044: ent = 7'o037;
            9'h04D: ent = 7'o040;  9'h015: ent = 7'o041;  9'h02D: ent = 7'o042;  9'h01B: ent = 7'o043;
            9'h02C: ent = 7'o044;  9'h03C: ent = 7'o045;  9'h02A: ent = 7'o046;  9'h01D: ent = 7'o047;
            9'h022: ent = 7'o050;  9'h035: ent = 7'o051;  9'h01A: ent = 7'o052;  9'h05B: ent = 7'o053;
            9'h06A: ent = 7'o054;  9'h05D: ent = 7'o055;  9'h055: ent = 7'o056;  9'h04E: ent = 7'o057;
            9'h045: ent = 7'o060;  9'h016: ent = 7'o061;  9'h01E: ent = 7'o062;  9'h026: ent = 7'o063;
            9'h025: ent = 7'o064;  9'h02E: ent = 7'o065;  9'h036: ent = 7'o066;  9'h03D: ent = 7'o067;
            9'h03E: ent = 7'o070;  9'h046: ent = 7'o071;  9'h052: ent = 7'o072;  9'h04C: ent = 7'o073;
            9'h041: ent = 7'o074;  9'h049: ent = 7'o075;  9'h04A: ent = 7'o076;  9'h051: ent = 7'o077;
            // Row 8: HOME UP RIGHT INS/DEL GRPH KANA SHIFT CTRL
            9'h16C: ent = 7'o100;  9'h175: ent = 7'o101;  9'h174: ent = 7'o102;  9'h066: ent = 7'o103;
            9'h171: ent = 7'o103;  9'h011: ent = 7'o104;  9'h111: ent = 7'o105;  9'h012: ent = 7'o106;
            9'h059: ent = 7'o106;  9'h014: ent = 7'o107;  9'h114: ent = 7'o107;
            // Row 9: STOP (F9) F1-F5 SPACE ESC
            9'h001: ent = 7'o110;  9'h005: ent = 7'o111;  9'h006: ent = 7'o112;  9'h004: ent = 7'o113;
            9'h00C: ent = 7'o114;  9'h003: ent = 7'o115;  9'h029: ent = 7'o116;  9'h076: ent = 7'o117;
            default: hit = 1'b0;
        endcase
    end

    assign row = ent.row;
    assign col = ent.col;

endmodule

// File: rtl/ps2_keymatrix.sv
// PS/2 controller consumer: polls and pops scancodes, tracks set-2 prefixes and
// maintains the active-low PC-8001 key matrix read by the CPU at ports 00h-09h.
module ps2_keymatrix
    import ps2_pkg::*;
#(
    parameter bit         SEND_RESET = 1'b1,
    parameter logic [7:0] INIT_CMD   = 8'hFF,
    parameter int         ROWS       = 10
) (
    input  logic       I_CLK,
    input  logic       I_RST_N,
    output logic [1:0] O_PS2_ADDR,
    output logic       O_PS2_WRITE,
    output logic [7:0] O_PS2_WRDATA,
    input  logic [7:0] I_PS2_RDDATA,
    input  logic [3:0] I_KEYROW,
    output logic [7:0] O_KEYDATA,
    output logic       O_KEYEVT
);

    localparam logic [4:0] ROWS_L = 5'(ROWS);

    state_t     state_q, state_d;
    logic [1:0] addr_q, addr_d;
    logic       write_q, write_d;
    logic [7:0] wrdata_q, wrdata_d;
    logic [7:0] code_q, code_d;
    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic [2:0] skip_q, skip_d;
    logic       evt_q, evt_d;
    logic [7:0] mat_q [ROWS];
    logic [7:0] mat_d [ROWS];

    logic       km_hit;
    logic [3:0] km_row;
    logic [2:0] km_col;
    logic       km_row_ok;

    ps2_keymap u_keymap (
        .ext  (ext_q),
        .code (code_q),
        .hit  (km_hit),
        .row  (km_row),
        .col  (km_col)
    );

    assign km_row_ok = {1'b0, km_row} < ROWS_L;

    // Each state's address is registered on entry, so rddata seen in a state
    // always belongs to the address that state presents.
    always_comb begin
        state_d  = state_q;
        addr_d   = ADDR_STAT;
        write_d  = 1'b0;
        wrdata_d = 8'h00;
        code_d   = code_q;
        ext_d    = ext_q;
        brk_d    = brk_q;
        skip_d   = skip_q;
        evt_d    = 1'b0;
        mat_d    = mat_q;
        case (state_q)
            ST_INIT: begin
                if (I_PS2_RDDATA[1]) begin
                    state_d  = ST_SEND;
                    addr_d   = ADDR_TX;
                    write_d  = 1'b1;
                    wrdata_d = INIT_CMD;
                end
            end
            ST_SEND: state_d = ST_POLL;
            ST_POLL: begin
                if (I_PS2_RDDATA[0]) begin
                    state_d = ST_FETCH;
                    addr_d  = ADDR_RX;
                end
            end
            ST_FETCH: begin
                code_d  = I_PS2_RDDATA;
                state_d = ST_CLR;
                write_d = 1'b1;
            end
            ST_CLR: state_d = ST_DECODE;
            ST_DECODE: begin
                state_d = ST_POLL;
                if (skip_q != 3'd0) begin
                    skip_d = skip_q - 3'd1;
                end else if (code_q == CODE_E1) begin
                    skip_d = PAUSE_SKIP;
                end else if (code_q == CODE_E0) begin
                    ext_d = 1'b1;
                end else if (code_q == CODE_F0) begin
                    brk_d = 1'b1;
                end else if (code_q == CODE_AA || code_q == CODE_FA) begin
                    skip_d = skip_q;
                end else if (code_q == 8'h00 || code_q == 8'hFF) begin
                    for (int r = 0; r < ROWS; r++) begin
                        if (mat_q[r] != 8'hFF) evt_d = 1'b1;
                        mat_d[r] = 8'hFF;
                    end
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end else begin
                    if (km_hit && km_row_ok) begin
                        mat_d[km_row][km_col] = brk_q;
                        evt_d = mat_q[km_row][km_col] != brk_q;
                    end
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
            end
            default: state_d = ST_POLL;
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            if (SEND_RESET) state_q <= ST_INIT;
            else            state_q <= ST_POLL;
            addr_q   <= ADDR_STAT;
            write_q  <= 1'b0;
            wrdata_q <= 8'h00;
            code_q   <= 8'h00;
            ext_q    <= 1'b0;
            brk_q    <= 1'b0;
            skip_q   <= 3'd0;
            evt_q    <= 1'b0;
            for (int r = 0; r < ROWS; r++) mat_q[r] <= 8'hFF;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            wrdata_q <= wrdata_d;
            code_q   <= code_d;
            ext_q    <= ext_d;
            brk_q    <= brk_d;
            skip_q   <= skip_d;
            evt_q    <= evt_d;
            mat_q    <= mat_d;
        end
    end

    assign O_PS2_ADDR   = addr_q;
    assign O_PS2_WRITE  = write_q;
    assign O_PS2_WRDATA = wrdata_q;
    assign O_KEYEVT     = evt_q;
    assign O_KEYDATA    = ({1'b0, I_KEYROW} < ROWS_L) ? mat_q[I_KEYROW] : 8'hFF;

endmodule

// File: tb/tb_ps2_keymatrix.sv
// Bench for ps2_keymatrix: a register-level PS/2 controller stand-in feeds
// scancodes; a key-state model predicts the matrix, event count and host writes.
module tb_ps2_keymatrix;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] ps2_addr;
    logic       ps2_write;
    logic [7:0] ps2_wrdata;
    logic [7:0] ps2_rddata;
    logic [3:0] keyrow;
    logic [7:0] keydata;
    logic       keyevt;

    ps2_keymatrix dut (
        .I_CLK        (clk),
        .I_RST_N      (rst_n),
        .O_PS2_ADDR   (ps2_addr),
        .O_PS2_WRITE  (ps2_write),
        .O_PS2_WRDATA (ps2_wrdata),
        .I_PS2_RDDATA (ps2_rddata),
        .I_KEYROW     (keyrow),
        .O_KEYDATA    (keydata),
        .O_KEYEVT     (keyevt)
    );

    always #20 clk = ~clk;

    // Controller stand-in: one pending rx byte, popped by a write of 0 to addr 0
    logic       ctl_empty;
    logic [7:0] rx_byte;
    int         push_cnt = 0;
    int         pop_cnt  = 0;

    assign ps2_rddata = (ps2_addr == 2'd0) ? {6'b0, ctl_empty, (push_cnt != pop_cnt)} :
                        (ps2_addr == 2'd1) ? rx_byte : 8'h00;

    always @(posedge clk) begin
        if (ps2_write && ps2_addr == 2'd0 && push_cnt != pop_cnt) pop_cnt <= pop_cnt + 1;
    end

    // Key-state model
    logic [7:0] exp_mat [16];
    bit         m_ext, m_brk;
    int         m_skip;
    int         exp_evt = 0, exp_tx = 0, exp_pend = 0;

    function automatic int key_pos(input bit ext, input logic [7:0] code);
        case ({ext, code})
            9'h01C: return 2 * 8 + 1;   // A
            9'h015: return 4 * 8 + 1;   // Q
            9'h012: return 8 * 8 + 6;   // left shift
            9'h014: return 8 * 8 + 7;   // ctrl
            9'h029: return 9 * 8 + 6;   // space
            9'h175: return 8 * 8 + 1;   // cursor up
            9'h075: return 1 * 8 + 0;   // keypad 8
            9'h05A: return 1 * 8 + 7;   // return
            default: return -1;         // includes 77 (NumLock) and E0 12
        endcase
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 16; r++) exp_mat[r] = 8'hFF;
        m_ext = 0; m_brk = 0; m_skip = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int p;
        bit any;
        any = 0;
        if (m_skip > 0) m_skip--;
        else if (b == 8'hE1) m_skip = 7;
        else if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hAA || b == 8'hFA) begin end
        else if (b == 8'h00 || b == 8'hFF) begin
            for (int r = 0; r < 10; r++) begin
                if (exp_mat[r] != 8'hFF) any = 1;
                exp_mat[r] = 8'hFF;
            end
            if (any) exp_evt++;
            m_ext = 0; m_brk = 0;
        end else begin
            p = key_pos(m_ext, b);
            if (p >= 0) begin
                if (exp_mat[p / 8][p % 8] != m_brk) exp_evt++;
                exp_mat[p / 8][p % 8] = m_brk;
            end
            m_ext = 0; m_brk = 0;
        end
    endtask

    // Compare process
    bit         rst_chk = 0, mdl_en = 0, lit_en = 0, cnt_en = 0, idle_chk = 0;
    logic [7:0] lit_exp = 8'h00;
    string      lit_name = "";
    int         total = 0, bad = 0, act_evt = 0, act_tx = 0;

    function automatic int chk(input string name, input int act, input int exp);
        if (act != exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
            return 1;
        end
        return 0;
    endfunction

    always @(negedge clk) begin : cmp
        int t;
        int b;
        t = 0; b = 0;
        if (rst_chk) begin
            t += 5;
            b += chk("rst_addr", ps2_addr, 0);
            b += chk("rst_write", ps2_write, 0);
            b += chk("rst_wrdata", ps2_wrdata, 0);
            b += chk("rst_keyevt", keyevt, 0);
            b += chk("rst_keydata", keydata, 8'hFF);
        end
        if (mdl_en) begin
            t += 1;
            b += chk($sformatf("model_row%0d", keyrow), keydata, exp_mat[keyrow]);
        end
        if (lit_en) begin
            t += 1;
            b += chk(lit_name, keydata, lit_exp);
        end
        if (idle_chk) begin
            t += 2;
            b += chk("idle_addr", ps2_addr, 0);
            b += chk("idle_write", ps2_write, 0);
        end
        if (cnt_en) begin
            t += 3;
            b += chk("keyevt_count", act_evt, exp_evt);
            b += chk("tx_write_count", act_tx, exp_tx);
            b += chk("rx_pending", push_cnt - pop_cnt, exp_pend);
        end
        if (ps2_write && ps2_addr == 2'd2) begin
            t += 1;
            b += chk("tx_data", ps2_wrdata, 8'hFF);
        end
        act_evt <= act_evt + (keyevt ? 1 : 0);
        act_tx  <= act_tx + ((ps2_write && ps2_addr == 2'd2) ? 1 : 0);
        total   <= total + t;
        bad     <= bad + b;
    end

    // Stimulus helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input int row, input logic [7:0] exp);
        tick();
        keyrow = 4'(row); lit_exp = exp; lit_name = name; lit_en = 1;
        tick();
        lit_en = 0;
    endtask

    task automatic cnt();
        tick();
        cnt_en = 1;
        tick();
        cnt_en = 0;
    endtask

    task automatic sweep();
        for (int r = 0; r < 16; r++) begin
            tick();
            keyrow = 4'(r);
        end
        tick();
    endtask

    task automatic wait_consume(input logic [7:0] b);
        int n;
        n = 0;
        while (pop_cnt != push_cnt) begin
            tick();
            n++;
            if (n > 40) begin
                $display("FAIL pop_timeout: byte %02h still pending after %0d cycles, expected pop", b, n);
                $fatal(1, "controller byte never consumed");
            end
        end
        repeat (3) tick();
        model_byte(b);
        mdl_en = 1;
    endtask

    task automatic send(input logic [7:0] b);
        mdl_en = 0;
        rx_byte = b;
        push_cnt++;
        wait_consume(b);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; ctl_empty = 1'b0; keyrow = 4'd0; rx_byte = 8'h00;
        model_reset();

        // Reset values, then INIT must hold while the controller is not empty
        tick();
        rst_chk = 1; mdl_en = 1;
        for (int r = 0; r < 16; r += 5) begin
            keyrow = 4'(r);
            tick();
        end
        rst_chk = 0;
        rst_n = 1'b1;
        idle_chk = 1; repeat (10) tick(); idle_chk = 0;
        cnt();

        // Status 02: exactly one reset command, then polling at addr 0
        ctl_empty = 1'b1; exp_tx = 1;
        repeat (6) tick();
        idle_chk = 1; repeat (5) tick(); idle_chk = 0;
        cnt();

        // Make / break of A
        send(8'h1C);
        lit("a_make_row2", 2, 8'hFD);
        send(8'hF0); send(8'h1C);
        lit("a_break_row2", 2, 8'hFF);
        cnt();

        // Typematic shift, then space
        send(8'h12); send(8'h12); send(8'h29);
        lit("shift_row8", 8, 8'hBF);
        lit("space_row9", 9, 8'hBF);
        cnt();

        // Extended UP versus keypad 8
        send(8'hE0); send(8'h75);
        lit("up_make_row8", 8, 8'hBD);
        send(8'hE0); send(8'hF0); send(8'h75);
        lit("up_break_row8", 8, 8'hBF);
        send(8'h75);
        lit("kp8_row1", 1, 8'hFE);
        lit("kp8_not_up_row8", 8, 8'hBF);
        send(8'hF0); send(8'h75);
        send(8'hF0); send(8'h12);
        send(8'hF0); send(8'h29);
        cnt();

        // Pause sequence is swallowed whole
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        sweep();
        lit("pause_row8", 8, 8'hFF);
        cnt();
        send(8'h5A);
        lit("ret_row1", 1, 8'h7F);
        send(8'hF0); send(8'h5A);

        // Overrun releases everything and clears a pending break prefix
        send(8'h1C); send(8'h12);
        lit("two_keys_row2", 2, 8'hFD);
        send(8'h00);
        sweep();
        lit("overrun_row2", 2, 8'hFF);
        lit("overrun_row8", 8, 8'hFF);
        cnt();
        send(8'hF0); send(8'h00); send(8'h1C);
        lit("after_overrun_make", 2, 8'hFD);
        send(8'hF0); send(8'hAA); send(8'h1C);
        lit("aa_keeps_break", 2, 8'hFF);
        send(8'hE0); send(8'h12); send(8'h12);
        lit("e0_miss_clears_ext", 8, 8'hBF);
        send(8'hF0); send(8'h12);
        lit("row12_reads_ff", 12, 8'hFF);
        lit("row15_reads_ff", 15, 8'hFF);
        cnt();

        // Reset during FETCH: matrix cleared, back in INIT, byte left pending
        send(8'h1C);
        lit("pre_reset_row2", 2, 8'hFD);
        mdl_en = 0;
        rx_byte = 8'h15; push_cnt++;
        n = 0;
        while (ps2_addr != 2'd1) begin
            tick();
            n++;
            if (n > 40) begin
                $display("FAIL fetch_timeout: addr %0d after %0d cycles, expected 1", ps2_addr, n);
                $fatal(1, "fetch never reached");
            end
        end
        #2 rst_n = 1'b0;
        ctl_empty = 1'b0;
        model_reset();
        keyrow = 4'd2; rst_chk = 1; mdl_en = 1;
        tick(); tick();
        rst_chk = 0;
        rst_n = 1'b1;
        idle_chk = 1; repeat (10) tick(); idle_chk = 0;
        exp_pend = 1;
        cnt();
        exp_pend = 0; exp_tx = 2;
        ctl_empty = 1'b1;
        mdl_en = 0;
        wait_consume(8'h15);
        lit("q_after_reset_row4", 4, 8'hFD);
        sweep();
        cnt();

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
